// File: rtl/lcd_ctrl_if.sv
// LCD write-port bundle: the LSU's LCD word in, the HD44780 pins and status out.
interface lcd_ctrl_if;
    logic [31:0] io_lcd_i;
    logic        lcd_on_o;
    logic        lcd_en_o;
    logic        lcd_rs_o;
    logic        lcd_rw_o;
    logic [7:0]  lcd_data_o;
    logic        busy_o;
    logic        ovf_o;

    modport slave (
        input  io_lcd_i,
        output lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o, busy_o, ovf_o
    );

    modport master (
        output io_lcd_i,
        input  lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o, busy_o, ovf_o
    );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780 write controller: turns GO-bit toggles in the LSU's LCD word into timed
// RS/DATA/EN transfers, with a one-entry request buffer and busy/overflow status.
//
// state   | meaning
// POWERUP | waiting for LCD power-up; requests are buffered
// IDLE    | no transfer in progress
// SETUP   | RS/DATA driven, EN low
// PULSE   | EN high
// HOLD    | EN low, RS/DATA still held
// EXEC    | waiting for the LCD to execute the instruction
module lcd_ctrl #(
    parameter int unsigned SETUP_CYC     = 3,
    parameter int unsigned EN_HIGH_CYC   = 15,
    parameter int unsigned HOLD_CYC      = 3,
    parameter int unsigned EXEC_CYC      = 2000,
    parameter int unsigned EXEC_LONG_CYC = 82000,
    parameter int unsigned POWERUP_CYC   = 1000000
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    lcd_ctrl_if.slave bus
);

    localparam int unsigned MAX_A   = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
    localparam int unsigned MAX_B   = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int unsigned MAX_C   = (MAX_B > EXEC_CYC) ? MAX_B : EXEC_CYC;
    localparam int unsigned MAX_D   = (MAX_C > EXEC_LONG_CYC) ? MAX_C : EXEC_LONG_CYC;
    localparam int unsigned MAX_CYC = (MAX_D > POWERUP_CYC) ? MAX_D : POWERUP_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 1);
    localparam logic [CW-1:0] LONG_LD  = CW'(EXEC_LONG_CYC - 1);
    localparam logic [CW-1:0] PU_LD    = CW'(POWERUP_CYC - 1);

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          pend_rs_q, pend_rs_d;
    logic [7:0]    pend_data_q, pend_data_d;
    logic          prev_go_q;
    logic          primed_q;
    logic          on_q;
    logic          en_q, en_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;

    logic          go;
    logic          req;
    logic          req_rs;
    logic [7:0]    req_data;
    logic          cnt_done;
    logic [CW-1:0] cnt_dec;
    logic          long_cmd;
    logic          take_pend;
    logic          take_req;
    logic          unused_bits;

    assign go          = bus.io_lcd_i[10];
    assign req_rs      = bus.io_lcd_i[9];
    assign req_data    = bus.io_lcd_i[7:0];
    assign unused_bits = ^{bus.io_lcd_i[30:11], bus.io_lcd_i[8]};

    // The first cycle after reset only captures GO, so a GO left high is not a request.
    assign req      = primed_q && (go != prev_go_q);
    assign cnt_done = (cnt_q == '0);
    assign cnt_dec  = cnt_q - CW'(1);
    assign long_cmd = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_rs_d   = pend_rs_q;
        pend_data_d = pend_data_q;
        en_d        = en_q;
        rs_d        = rs_q;
        data_d      = data_q;
        ovf_d       = ovf_q;
        take_pend   = 1'b0;
        take_req    = 1'b0;

        case (state_q)
            ST_POWERUP: begin
                if (!primed_q) begin
                    cnt_d = PU_LD;
                end else if (cnt_done) begin
                    if (pend_q) begin
                        state_d   = ST_SETUP;
                        take_pend = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_IDLE: begin
                if (pend_q) begin
                    state_d   = ST_SETUP;
                    take_pend = 1'b1;
                end else if (req) begin
                    state_d  = ST_SETUP;
                    take_req = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_done) begin
                    state_d = ST_PULSE;
                    en_d    = 1'b1;
                    cnt_d   = EN_LD;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_PULSE: begin
                if (cnt_done) begin
                    state_d = ST_HOLD;
                    en_d    = 1'b0;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_HOLD: begin
                if (cnt_done) begin
                    state_d = ST_EXEC;
                    cnt_d   = long_cmd ? LONG_LD : EXEC_LD;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_EXEC: begin
                if (cnt_done) begin
                    if (pend_q) begin
                        state_d   = ST_SETUP;
                        take_pend = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                state_d = ST_POWERUP;
                en_d    = 1'b0;
            end
        endcase

        if (take_pend) begin
            rs_d   = pend_rs_q;
            data_d = pend_data_q;
            pend_d = 1'b0;
            cnt_d  = SETUP_LD;
        end
        if (take_req) begin
            rs_d   = req_rs;
            data_d = req_data;
            cnt_d  = SETUP_LD;
        end

        // A request landing on the edge that drains the buffer reuses the freed slot.
        if (req && !take_req) begin
            if (!pend_q || take_pend) begin
                pend_d      = 1'b1;
                pend_rs_d   = req_rs;
                pend_data_d = req_data;
            end else begin
                ovf_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE) || pend_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_POWERUP;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_rs_q   <= 1'b0;
            pend_data_q <= 8'h00;
            prev_go_q   <= 1'b0;
            primed_q    <= 1'b0;
            on_q        <= 1'b0;
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_rs_q   <= pend_rs_d;
            pend_data_q <= pend_data_d;
            prev_go_q   <= go;
            primed_q    <= 1'b1;
            on_q        <= bus.io_lcd_i[31];
            en_q        <= en_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.lcd_on_o   = on_q;
    assign bus.lcd_en_o   = en_q;
    assign bus.lcd_rs_o   = rs_q;
    assign bus.lcd_rw_o   = 1'b0;
    assign bus.lcd_data_o = data_q;
    assign bus.busy_o     = busy_q;
    assign bus.ovf_o      = ovf_q;

endmodule
